// File: rtl/sa_feeder.sv
// rtl/sa_feeder.sv - vector FIFO, diagonal skew and frame sequencing for the 5x5 systolic array
// Define SA_FEEDER_AUTOCLEAR_EN to add the CLEAR state and the per-frame clear_out pulse.
module sa_feeder #(
  parameter int DATA_W      = 8,
  parameter int ROWS        = 5,
  parameter int DEPTH       = 4,
  parameter int DRAIN_EXTRA = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ROWS*DATA_W-1:0] in_vec,
  input  logic                   in_last,
  output logic [ROWS*DATA_W-1:0] feed_data,
  output logic                   clear_out,
  output logic                   busy,
  output logic                   done
);
  localparam int VW        = ROWS * DATA_W;
  localparam int AW        = $clog2(DEPTH);
  localparam int DRAIN_LEN = ROWS - 1 + DRAIN_EXTRA;
  localparam int CW        = $clog2(DRAIN_LEN + 1);

  typedef enum logic [1:0] {IDLE, CLEAR, STREAM, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [VW:0]     mem_q [DEPTH];
  logic [VW:0]     mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            full, empty, push, pop;
  logic [VW:0]     head;
  logic [VW-1:0]   skew_in;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign in_ready = !rst && !full;
  assign push     = in_valid && in_ready;
  assign pop      = (state_q == STREAM) && !empty;
  assign head     = mem_q[rd_ptr_q];
  assign skew_in  = pop ? head[VW-1:0] : '0;

  // Storage has no fall-through: the head is only read from registered state.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = {in_last, in_vec};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (!empty) begin
`ifdef SA_FEEDER_AUTOCLEAR_EN
          state_d = CLEAR;
`else
          state_d = STREAM;
`endif
        end
      end
      CLEAR: state_d = STREAM;
      STREAM: begin
        if (pop && head[VW]) begin
          state_d = DRAIN;
          cnt_d   = CW'(DRAIN_LEN - 1);
        end
      end
      DRAIN: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    // done is registered so it lines up with the last DRAIN cycle, not the one after.
    done_d = (state_d == DRAIN) && (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign busy = busy_q;
  assign done = done_q;

`ifdef SA_FEEDER_AUTOCLEAR_EN
  logic clear_q, clear_d;

  always_comb begin
    clear_d = (state_q == CLEAR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clear_q <= 1'b0;
    end else begin
      clear_q <= clear_d;
    end
  end

  assign clear_out = clear_q;
`else
  assign clear_out = 1'b0;
`endif

  // Row g (0-based) is a g+1 deep shift chain; the oldest slot is the row output.
  for (genvar g = 0; g < ROWS; g++) begin : g_row
    localparam int L = (g + 1) * DATA_W;
    logic [L-1:0] pipe_q, pipe_d;

    always_comb begin
      pipe_d = (pipe_q << DATA_W) | L'(skew_in[g*DATA_W +: DATA_W]);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        pipe_q <= '0;
      end else begin
        pipe_q <= pipe_d;
      end
    end

    assign feed_data[g*DATA_W +: DATA_W] = pipe_q[L-1 -: DATA_W];
  end

endmodule

// File: tb/tb_sa_feeder.sv
// tb/tb_sa_feeder.sv - directed and random checks of sa_feeder against a queue-based frame model
module tb_sa_feeder;
  localparam int DATA_W      = 8;
  localparam int ROWS        = 5;
  localparam int DEPTH       = 4;
  localparam int DRAIN_EXTRA = 5;
  localparam int VW          = ROWS * DATA_W;
  localparam int DRAIN_LEN   = ROWS - 1 + DRAIN_EXTRA;
`ifdef SA_FEEDER_AUTOCLEAR_EN
  localparam int AUTOCLEAR = 1;
`else
  localparam int AUTOCLEAR = 0;
`endif
  localparam int M_IDLE = 0, M_CLEAR = 1, M_STREAM = 2, M_DRAIN = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] in_vec;
  logic          in_last;
  logic [VW-1:0] feed_data;
  logic          clear_out;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  sa_feeder #(.DATA_W(DATA_W), .ROWS(ROWS), .DEPTH(DEPTH), .DRAIN_EXTRA(DRAIN_EXTRA)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .in_last(in_last), .feed_data(feed_data), .clear_out(clear_out), .busy(busy), .done(done)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pops = 0;
  logic [VW:0]   mq[$];
  int            mode = M_IDLE;
  int            drain_left = 0;
  logic [VW-1:0] hist [ROWS];
  logic          acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check in_ready, advance the model, check registered outputs.
  task automatic tick(input logic v, input logic [VW-1:0] vec, input logic l, input logic r);
    logic [VW-1:0] inj;
    logic [VW-1:0] ef;
    logic [VW:0]   e;
    logic          exp_rdy;
    logic          was_clear;
    in_valid = v;
    in_vec   = vec;
    in_last  = l;
    rst      = r;
    #1;
    exp_rdy = !r && (mq.size() < DEPTH);
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    acc       = v && exp_rdy;
    inj       = '0;
    was_clear = 1'b0;
    if (r) begin
      mq.delete();
      mode       = M_IDLE;
      drain_left = 0;
    end else begin
      was_clear = (mode == M_CLEAR);
      case (mode)
        M_IDLE:   if (mq.size() > 0) mode = (AUTOCLEAR != 0) ? M_CLEAR : M_STREAM;
        M_CLEAR:  mode = M_STREAM;
        M_STREAM: begin
          if (mq.size() > 0) begin
            e   = mq.pop_front();
            inj = e[VW-1:0];
            pops++;
            if (e[VW]) begin
              mode       = M_DRAIN;
              drain_left = DRAIN_LEN;
            end
          end
        end
        default: begin
          drain_left--;
          if (drain_left == 0) mode = M_IDLE;
        end
      endcase
      if (acc) mq.push_back({l, vec});
    end
    for (int k = ROWS - 1; k > 0; k--) hist[k] = r ? '0 : hist[k-1];
    hist[0] = inj;
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < ROWS; k++) ef[k*DATA_W +: DATA_W] = hist[k][k*DATA_W +: DATA_W];
    chk("feed_data", 64'(feed_data), 64'(ef));
    chk("clear_out", 64'(clear_out), 64'(was_clear));
    chk("busy", 64'(busy), 64'(mode != M_IDLE));
    chk("done", 64'(done), 64'((mode == M_DRAIN) && (drain_left == 1)));
  endtask

  logic [VW-1:0] v1, v2, v3, rv;
  logic [VW-1:0] bp [7];
  int a, first_seen, row5_seen, nclr, nclr_before, ndone, idx, low_seen, bsent, p0, guard;

  initial begin
    for (int k = 0; k < ROWS; k++) hist[k] = '0;
    in_valid = 1'b0;
    in_vec   = '0;
    in_last  = 1'b0;
    rst      = 1'b1;
    tick(0, '0, 0, 1);
    tick(0, '0, 0, 1);
    tick(0, '0, 0, 0);

    // Single 3-vector frame with known elements.
    v1 = {8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    v2 = {8'd10, 8'd9, 8'd8, 8'd7, 8'd6};
    v3 = {8'd15, 8'd14, 8'd13, 8'd12, 8'd11};
    a = cyc; first_seen = -1; row5_seen = -1; nclr = 0; nclr_before = 0; ndone = 0;
    for (int i = 0; i < 25; i++) begin
      case (i)
        0:       tick(1, v1, 0, 0);
        1:       tick(1, v2, 0, 0);
        2:       tick(1, v3, 1, 0);
        default: tick(0, '0, 0, 0);
      endcase
      if (clear_out && first_seen < 0) nclr_before++;
      if (first_seen < 0 && feed_data[7:0] == 8'd1) first_seen = cyc;
      if (row5_seen < 0 && feed_data[39:32] == 8'd5) row5_seen = cyc;
      nclr += int'(clear_out);
      ndone += int'(done);
    end
    chk("first_latency", 64'(first_seen - a - 1), 64'((AUTOCLEAR != 0) ? 3 : 2));
    chk("row5_skew", 64'(row5_seen - first_seen), 64'(4));
    chk("clear_before_first", 64'(nclr_before), 64'(AUTOCLEAR));
    chk("clear_count", 64'(nclr), 64'(AUTOCLEAR));
    chk("done_count", 64'(ndone), 64'(1));

    // Backpressure: a one-vector frame, then six more pushed back-to-back while it drains.
    for (int i = 0; i < 7; i++) bp[i] = VW'({$urandom(), $urandom()});
    idx = 0; low_seen = 0;
    for (int i = 0; i < 60; i++) begin
      if (idx < 7) begin
        tick(1, bp[idx], (idx == 0) || (idx == 6), 0);
        if (acc) idx++;
      end else begin
        tick(0, '0, 0, 0);
      end
      if (!in_ready) low_seen = 1;
    end
    chk("bp_ready_dropped", 64'(low_seen), 64'(1));
    chk("bp_all_accepted", 64'(idx), 64'(7));

    // Mid-frame gaps while streaming.
    tick(1, VW'({$urandom(), $urandom()}), 0, 0);
    for (int i = 0; i < 4; i++) tick(0, '0, 0, 0);
    tick(1, VW'({$urandom(), $urandom()}), 0, 0);
    for (int i = 0; i < 2; i++) tick(0, '0, 0, 0);
    tick(1, VW'({$urandom(), $urandom()}), 1, 0);
    for (int i = 0; i < 20; i++) tick(0, '0, 0, 0);

    // Back-to-back frames: frame B is pushed during frame A's drain.
    tick(1, VW'({$urandom(), $urandom()}), 0, 0);
    tick(1, VW'({$urandom(), $urandom()}), 1, 0);
    bsent = 0; nclr = 0; ndone = 0;
    for (int i = 0; i < 45; i++) begin
      if (mode == M_DRAIN && bsent < 2) begin
        tick(1, VW'({$urandom(), $urandom()}), bsent == 1, 0);
        if (acc) bsent++;
      end else begin
        tick(0, '0, 0, 0);
      end
      nclr += int'(clear_out);
      ndone += int'(done);
    end
    chk("b2b_clear_count", 64'(nclr), 64'(2 * AUTOCLEAR));
    chk("b2b_done_count", 64'(ndone), 64'(2));

    // Reset in the cycle after the second pop of a 4-vector frame.
    p0 = pops; guard = 0;
    while (pops - p0 < 2 && guard < 20) begin
      tick(guard < 4, VW'({$urandom(), $urandom()}), guard == 3, 0);
      guard++;
    end
    chk("two_pops_reached", 64'(pops - p0 >= 2), 64'(1));
    tick(0, '0, 0, 1);
    chk("rst_feed_zero", 64'(feed_data), 64'(0));
    chk("rst_busy_low", 64'(busy), 64'(0));
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick(0, '0, 0, 0);
      ndone += int'(done);
    end
    chk("rst_no_done", 64'(ndone), 64'(0));
    chk("rst_fifo_empty", 64'(busy), 64'(0));

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      rv = VW'({$urandom(), $urandom()});
      tick(1'($urandom_range(1)), rv, ($urandom_range(3) == 0), 0);
    end
    tick(1, VW'({$urandom(), $urandom()}), 1, 0);
    for (int i = 0; i < 40; i++) tick(0, '0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
